// File: rtl/xip_pkg.sv
// Shared types and constants for the XIP prefetch line buffer.
// Holds the controller state encoding and the default line size.
package xip_pkg;

    localparam int XIP_LINE_WORDS = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_PASS = 2'd2
    } xip_state_e;

endpackage

// File: rtl/xip_prefetch_buf.sv
// Single-line prefetch buffer between an OBI host and the XIP flash core.
// Optional hit/miss counters are built when XIP_PREFETCH_PERF_EN is defined.
module xip_prefetch_buf
    import xip_pkg::*;
#(
    parameter int LINE_WORDS = XIP_LINE_WORDS
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        s_req_i,
    input  logic        s_we_i,
    input  logic [3:0]  s_be_i,
    input  logic [31:0] s_addr_i,
    input  logic [31:0] s_data_i,
    output logic        s_gnt_o,
    output logic        s_rvalid_o,
    output logic [31:0] s_data_o,
    output logic        m_req_o,
    output logic        m_we_o,
    output logic [3:0]  m_be_o,
    output logic [31:0] m_addr_o,
    output logic [31:0] m_data_o,
    input  logic        m_gnt_i,
    input  logic        m_rvalid_i,
    input  logic [31:0] m_data_i,
    input  logic        flush_i
`ifdef XIP_PREFETCH_PERF_EN
    ,
    output logic [31:0] hit_cnt_o,
    output logic [31:0] miss_cnt_o
`endif
);

    localparam int LB = $clog2(LINE_WORDS);
    localparam int TW = 30 - LB;
    localparam logic [LB-1:0] LAST = LB'(LINE_WORDS - 1);

    xip_state_e    state_q;
    logic          valid_q;
    logic          flush_pend_q;
    logic [LB-1:0] cnt_q;
    logic [TW-1:0] tag_q;
    logic [TW-1:0] req_tag_q;
    logic [LB-1:0] req_word_q;
    logic [31:0]   line_q [LINE_WORDS];

    logic [TW-1:0] s_tag;
    logic [LB-1:0] s_word;
    logic          s_hit;
    logic          rd_fire;
    logic          wr_fire;
    logic          fill_beat;
    logic          fill_last;

    assign s_tag     = s_addr_i[31:LB+2];
    assign s_word    = s_addr_i[LB+1:2];
    assign s_gnt_o   = rst_ni & s_req_i & (state_q == S_IDLE);
    assign rd_fire   = s_gnt_o & ~s_we_i;
    assign wr_fire   = s_gnt_o & s_we_i;
    assign s_hit     = valid_q & (tag_q == s_tag) & ~flush_i;
    assign fill_beat = (state_q == S_FILL) & ~m_req_o & m_rvalid_i;
    assign fill_last = fill_beat & (cnt_q == LAST);

    // Line storage: capture each fill beat into its word slot (no reset).
    always_ff @(posedge clk_i) begin
        if (fill_beat) begin
            line_q[cnt_q] <= m_data_i;
        end
    end

    // Controller: hit service, line fill sequencing and write pass-through.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            valid_q      <= 1'b0;
            flush_pend_q <= 1'b0;
            cnt_q        <= '0;
            tag_q        <= '0;
            req_tag_q    <= '0;
            req_word_q   <= '0;
            s_rvalid_o   <= 1'b0;
            s_data_o     <= '0;
            m_req_o      <= 1'b0;
            m_we_o       <= 1'b0;
            m_be_o       <= '0;
            m_addr_o     <= '0;
            m_data_o     <= '0;
        end else begin
            s_rvalid_o <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (flush_i) begin
                        valid_q <= 1'b0;
                    end
                    if (wr_fire) begin
                        valid_q  <= 1'b0;
                        m_req_o  <= 1'b1;
                        m_we_o   <= 1'b1;
                        m_be_o   <= s_be_i;
                        m_addr_o <= s_addr_i;
                        m_data_o <= s_data_i;
                        state_q  <= S_PASS;
                    end else if (rd_fire && s_hit) begin
                        s_rvalid_o <= 1'b1;
                        s_data_o   <= line_q[s_word];
                    end else if (rd_fire) begin
                        valid_q      <= 1'b0;
                        flush_pend_q <= 1'b0;
                        req_tag_q    <= s_tag;
                        req_word_q   <= s_word;
                        cnt_q        <= '0;
                        m_req_o      <= 1'b1;
                        m_we_o       <= 1'b0;
                        m_be_o       <= 4'hF;
                        m_addr_o     <= {s_tag, {LB{1'b0}}, 2'b00};
                        m_data_o     <= '0;
                        state_q      <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (flush_i) begin
                        flush_pend_q <= 1'b1;
                    end
                    if (m_req_o && m_gnt_i) begin
                        m_req_o <= 1'b0;
                    end
                    if (fill_last) begin
                        s_rvalid_o   <= 1'b1;
                        s_data_o     <= (req_word_q == LAST) ?
                                        m_data_i : line_q[req_word_q];
                        tag_q        <= req_tag_q;
                        valid_q      <= ~(flush_pend_q | flush_i);
                        flush_pend_q <= 1'b0;
                        cnt_q        <= '0;
                        state_q      <= S_IDLE;
                    end else if (fill_beat) begin
                        cnt_q    <= cnt_q + LB'(1);
                        m_req_o  <= 1'b1;
                        m_addr_o <= {req_tag_q, cnt_q + LB'(1), 2'b00};
                    end
                end
                S_PASS: begin
                    if (m_req_o && m_gnt_i) begin
                        m_req_o <= 1'b0;
                    end
                    if (!m_req_o && m_rvalid_i) begin
                        s_rvalid_o <= 1'b1;
                        s_data_o   <= '0;
                        m_we_o     <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef XIP_PREFETCH_PERF_EN
    // Count granted reads by outcome; both counters wrap naturally.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else if (rd_fire) begin
            if (s_hit) begin
                hit_cnt_o <= hit_cnt_o + 32'd1;
            end else begin
                miss_cnt_o <= miss_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_xip_prefetch_buf.sv
// Directed bench for xip_prefetch_buf with a one-cycle flash responder.
// Table of read vectors plus hand sequences for fill corner cases.
module tb_xip_prefetch_buf;

    localparam int MISS_LAT = 8;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        s_req_i;
    logic        s_we_i;
    logic [3:0]  s_be_i;
    logic [31:0] s_addr_i;
    logic [31:0] s_data_i;
    logic        s_gnt_o;
    logic        s_rvalid_o;
    logic [31:0] s_data_o;
    logic        m_req_o;
    logic        m_we_o;
    logic [3:0]  m_be_o;
    logic [31:0] m_addr_o;
    logic [31:0] m_data_o;
    logic        m_gnt_i;
    logic        m_rvalid_i;
    logic [31:0] m_data_i;
    logic        flush_i;
    logic        gnt_en;
`ifdef XIP_PREFETCH_PERF_EN
    logic [31:0] hit_cnt_o;
    logic [31:0] miss_cnt_o;
`endif

    int checks = 0;
    int failures = 0;

    logic [31:0] log_addr [64];
    logic        log_we   [64];
    logic [31:0] log_data [64];
    logic [3:0]  log_be   [64];
    int          log_n = 0;

    xip_prefetch_buf dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .s_req_i    (s_req_i),
        .s_we_i     (s_we_i),
        .s_be_i     (s_be_i),
        .s_addr_i   (s_addr_i),
        .s_data_i   (s_data_i),
        .s_gnt_o    (s_gnt_o),
        .s_rvalid_o (s_rvalid_o),
        .s_data_o   (s_data_o),
        .m_req_o    (m_req_o),
        .m_we_o     (m_we_o),
        .m_be_o     (m_be_o),
        .m_addr_o   (m_addr_o),
        .m_data_o   (m_data_o),
        .m_gnt_i    (m_gnt_i),
        .m_rvalid_i (m_rvalid_i),
        .m_data_i   (m_data_i),
        .flush_i    (flush_i)
`ifdef XIP_PREFETCH_PERF_EN
        ,
        .hit_cnt_o  (hit_cnt_o),
        .miss_cnt_o (miss_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    assign m_gnt_i = m_req_o & gnt_en;

    function automatic logic [31:0] flash(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Flash model: respond one cycle after each granted request.
    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_rvalid_i <= 1'b0;
            m_data_i   <= '0;
        end else begin
            m_rvalid_i <= 1'b0;
            if (m_req_o && m_gnt_i) begin
                if (log_n < 64) begin
                    log_addr[log_n] <= m_addr_o;
                    log_we[log_n]   <= m_we_o;
                    log_data[log_n] <= m_data_o;
                    log_be[log_n]   <= m_be_o;
                    log_n           <= log_n + 1;
                end
                m_rvalid_i <= 1'b1;
                m_data_i   <= m_we_o ? 32'h0 : flash(m_addr_o);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic chk_reset_outs(input string nm);
        chk({nm, "_gnt"}, 32'(s_gnt_o), 32'd0);
        chk({nm, "_rvalid"}, 32'(s_rvalid_o), 32'd0);
        chk({nm, "_sdata"}, s_data_o, 32'd0);
        chk({nm, "_mreq"}, 32'(m_req_o), 32'd0);
        chk({nm, "_mwe"}, 32'(m_we_o), 32'd0);
        chk({nm, "_mbe"}, 32'(m_be_o), 32'd0);
        chk({nm, "_maddr"}, m_addr_o, 32'd0);
        chk({nm, "_mdata"}, m_data_o, 32'd0);
    endtask

    task automatic do_read(input logic [31:0] a, input logic fl,
                           output logic [31:0] d, output int lat);
        int n;
        @(negedge clk_i);
        s_req_i  = 1'b1;
        s_we_i   = 1'b0;
        s_addr_i = a;
        flush_i  = fl;
        #1;
        n = 0;
        while (!s_gnt_o && n < 50) begin
            @(negedge clk_i);
            #1;
            n++;
        end
        chk("rd_gnt", 32'(s_gnt_o), 32'd1);
        @(posedge clk_i);
        #1;
        s_req_i = 1'b0;
        flush_i = 1'b0;
        lat = 0;
        while (!s_rvalid_o && lat < 200) begin
            @(posedge clk_i);
            #1;
            lat++;
        end
        d = s_data_o;
        @(posedge clk_i);
        #1;
        chk("rd_pulse", 32'(s_rvalid_o), 32'd0);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] wd);
        int n;
        int lat;
        int base;
        base = log_n;
        @(negedge clk_i);
        s_req_i  = 1'b1;
        s_we_i   = 1'b1;
        s_be_i   = 4'hF;
        s_addr_i = a;
        s_data_i = wd;
        #1;
        n = 0;
        while (!s_gnt_o && n < 50) begin
            @(negedge clk_i);
            #1;
            n++;
        end
        chk("wr_gnt", 32'(s_gnt_o), 32'd1);
        @(posedge clk_i);
        #1;
        s_req_i = 1'b0;
        s_we_i  = 1'b0;
        lat = 0;
        while (!s_rvalid_o && lat < 200) begin
            @(posedge clk_i);
            #1;
            lat++;
        end
        chk("wr_lat", 32'(lat), 32'd2);
        chk("wr_rdata", s_data_o, 32'd0);
        chk("wr_cnt", 32'(log_n - base), 32'd1);
        chk("wr_addr", log_addr[base[5:0]], a);
        chk("wr_we", 32'(log_we[base[5:0]]), 32'd1);
        chk("wr_data", log_data[base[5:0]], wd);
        chk("wr_be", 32'(log_be[base[5:0]]), 32'hF);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        pre_fl;
        logic        co_fl;
        logic        miss;
    } vec_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vt [9];
        logic [31:0] b2b [4];
        logic [31:0] d;
        int          lat;
        int          base;
        int          w1;
        int          w2;

        vt[0] = '{32'h24, 1'b0, 1'b0, 1'b1};
        vt[1] = '{32'h20, 1'b0, 1'b0, 1'b0};
        vt[2] = '{32'h2C, 1'b0, 1'b0, 1'b0};
        vt[3] = '{32'h18, 1'b0, 1'b0, 1'b1};
        vt[4] = '{32'h1C, 1'b0, 1'b0, 1'b0};
        vt[5] = '{32'h18, 1'b0, 1'b1, 1'b1};
        vt[6] = '{32'h10, 1'b0, 1'b0, 1'b0};
        vt[7] = '{32'h14, 1'b1, 1'b0, 1'b1};
        vt[8] = '{32'h1C, 1'b0, 1'b0, 1'b0};
        b2b[0] = 32'h10;
        b2b[1] = 32'h18;
        b2b[2] = 32'h1C;
        b2b[3] = 32'h14;

        rst_ni   = 1'b1;
        s_req_i  = 1'b1;
        s_we_i   = 1'b0;
        s_be_i   = 4'h0;
        s_addr_i = 32'h14;
        s_data_i = 32'h0;
        flush_i  = 1'b0;
        gnt_en   = 1'b1;
        #2;
        rst_ni = 1'b0;
        #20;
        chk_reset_outs("reset");
        @(negedge clk_i);
        rst_ni  = 1'b1;
        s_req_i = 1'b0;

        // Cold read of 0x14
        base = log_n;
        do_read(32'h14, 1'b0, d, lat);
        chk("cold_data", d, flash(32'h14));
        chk("cold_lat", 32'(lat), 32'(MISS_LAT));
        chk("cold_cnt", 32'(log_n - base), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("cold_addr", log_addr[6'(base + i)], 32'h10 + 32'(4 * i));
            chk("cold_we", 32'(log_we[6'(base + i)]), 32'd0);
            chk("cold_be", 32'(log_be[6'(base + i)]), 32'hF);
        end

        // Back-to-back hits
        base = log_n;
        @(negedge clk_i);
        s_req_i  = 1'b1;
        s_we_i   = 1'b0;
        s_addr_i = b2b[0];
        #1;
        chk("b2b_gnt", 32'(s_gnt_o), 32'd1);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk_i);
            chk("b2b_rvalid", 32'(s_rvalid_o), 32'd1);
            chk("b2b_data", s_data_o, flash(b2b[i-1]));
            chk("b2b_mreq", 32'(m_req_o), 32'd0);
            s_addr_i = b2b[i];
            #1;
            chk("b2b_gnt", 32'(s_gnt_o), 32'd1);
        end
        @(negedge clk_i);
        chk("b2b_rvalid", 32'(s_rvalid_o), 32'd1);
        chk("b2b_data", s_data_o, flash(b2b[3]));
        s_req_i = 1'b0;
        @(negedge clk_i);
        chk("b2b_end", 32'(s_rvalid_o), 32'd0);
        chk("b2b_nomreq", 32'(log_n - base), 32'd0);

        // Vector table
        for (int i = 0; i < 9; i++) begin
            if (vt[i].pre_fl) begin
                @(negedge clk_i);
                flush_i = 1'b1;
                @(negedge clk_i);
                flush_i = 1'b0;
            end
            base = log_n;
            do_read(vt[i].addr, vt[i].co_fl, d, lat);
            chk("vec_data", d, flash(vt[i].addr));
            chk("vec_lat", 32'(lat), vt[i].miss ? 32'(MISS_LAT) : 32'd0);
            chk("vec_beats", 32'(log_n - base), vt[i].miss ? 32'd4 : 32'd0);
        end

        // Erase write passes through, then line refills
        do_write(32'h0080_0000, 32'h0);
        do_read(32'h14, 1'b0, d, lat);
        chk("erase_rd_data", d, flash(32'h14));
        chk("erase_rd_lat", 32'(lat), 32'(MISS_LAT));

        // Flush during second fill beat
        base = log_n;
        fork
            do_read(32'h44, 1'b0, d, lat);
            begin
                w1 = 0;
                while (log_n < base + 2 && w1 < 100) begin
                    @(negedge clk_i);
                    w1++;
                end
                chk("fl_beat2", 32'(log_n - base), 32'd2);
                flush_i = 1'b1;
                @(negedge clk_i);
                flush_i = 1'b0;
            end
        join
        chk("fl_data", d, flash(32'h44));
        chk("fl_lat", 32'(lat), 32'(MISS_LAT));
        do_read(32'h44, 1'b0, d, lat);
        chk("fl_reread_lat", 32'(lat), 32'(MISS_LAT));
        chk("fl_reread_data", d, flash(32'h44));
        do_read(32'h48, 1'b0, d, lat);
        chk("fl_hit_lat", 32'(lat), 32'd0);
        chk("fl_hit_data", d, flash(32'h48));

        // Downstream grant stalled 5 cycles
        gnt_en = 1'b0;
        base = log_n;
        fork
            do_read(32'h84, 1'b0, d, lat);
            begin
                w2 = 0;
                while (!m_req_o && w2 < 50) begin
                    @(negedge clk_i);
                    w2++;
                end
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk_i);
                    chk("stall_req", 32'(m_req_o), 32'd1);
                    chk("stall_addr", m_addr_o, 32'h80);
                end
                chk("stall_nolog", 32'(log_n - base), 32'd0);
                gnt_en = 1'b1;
            end
        join
        chk("stall_data", d, flash(32'h84));
        chk("stall_cnt", 32'(log_n - base), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("stall_addr_seq", log_addr[6'(base + i)],
                32'h80 + 32'(4 * i));
        end

        // Reset in the middle of a fill
        base = log_n;
        @(negedge clk_i);
        s_req_i  = 1'b1;
        s_we_i   = 1'b0;
        s_addr_i = 32'h104;
        #1;
        chk("mid_gnt", 32'(s_gnt_o), 32'd1);
        @(posedge clk_i);
        #1;
        s_req_i = 1'b0;
        w1 = 0;
        while (log_n < base + 2 && w1 < 100) begin
            @(negedge clk_i);
            w1++;
        end
        chk("mid_beats", 32'(log_n - base), 32'd2);
        rst_ni  = 1'b0;
        s_req_i = 1'b1;
        #1;
        chk_reset_outs("midrst");
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni  = 1'b1;
        s_req_i = 1'b0;
        @(negedge clk_i);
        chk("midrst_norsp", 32'(s_rvalid_o), 32'd0);
        base = log_n;
        do_read(32'h104, 1'b0, d, lat);
        chk("post_rst_lat", 32'(lat), 32'(MISS_LAT));
        chk("post_rst_data", d, flash(32'h104));
        chk("post_rst_first", log_addr[base[5:0]], 32'h100);
        do_read(32'h108, 1'b0, d, lat);
        chk("post_rst_hit", 32'(lat), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
